// File: rtl/alu_seq_if.sv
// Control-unit <-> sequential ALU bus: operation request, operands and the
// registered result/flag set returned on completion.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       OPSEL;
    logic [WIDTH-1:0] AC;
    logic [WIDTH-1:0] DR;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] RESULT;
    logic [WIDTH-1:0] HI;
    logic             E;
    logic             CO;
    logic             OVF;
    logic             N;
    logic             Z;
    logic             DZ;

    modport master (
        output start, OPSEL, AC, DR,
        input  busy, done, RESULT, HI, E, CO, OVF, N, Z, DZ
    );

    modport slave (
        input  start, OPSEL, AC, DR,
        output busy, done, RESULT, HI, E, CO, OVF, N, Z, DZ
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential accumulator ALU: single-cycle AC/DR ops plus iterative unsigned
// MUL (shift-add) and DIV (restoring), with the E flip-flop and status flags.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_LDA = 4'b0010;
    localparam logic [3:0] OP_CMA = 4'b0011;
    localparam logic [3:0] OP_CIR = 4'b0100;
    localparam logic [3:0] OP_CIL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [3:0] OP_CLE = 4'b1001;
    localparam logic [3:0] OP_CME = 4'b1010;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] work_hi_reg, work_hi_next;
    logic [WIDTH-1:0] work_lo_reg, work_lo_next;
    logic [WIDTH-1:0] operand_reg, operand_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic e_reg, e_next, co_reg, co_next, ovf_reg, ovf_next;
    logic n_reg, n_next, z_reg, z_next, dz_reg, dz_next, done_reg, done_next;

    logic [WIDTH:0]   add_sum, sub_sum, mul_sum, div_shift, div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] single_res, single_hi;
    logic             single_co, single_ovf, single_e, single_dz;

    assign add_sum   = {1'b0, bus.AC} + {1'b0, bus.DR};
    assign sub_sum   = {1'b0, bus.AC} + {1'b0, ~bus.DR} + {{WIDTH{1'b0}}, 1'b1};
    assign mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, operand_reg} : '0);
    // Remainder shifted left with the next dividend bit; trial-subtract the divisor.
    assign div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, operand_reg};
    assign div_ok    = (div_shift >= {1'b0, operand_reg});

    always_comb begin
        single_res = bus.AC;
        single_hi  = '0;
        single_co  = 1'b0;
        single_ovf = 1'b0;
        single_e   = e_reg;
        single_dz  = 1'b0;
        case (bus.OPSEL)
            OP_ADD: begin
                {single_co, single_res} = add_sum;
                single_ovf = (bus.AC[WIDTH-1] == bus.DR[WIDTH-1]) &&
                             (add_sum[WIDTH-1] != bus.AC[WIDTH-1]);
                single_e   = add_sum[WIDTH];
            end
            OP_AND: single_res = bus.AC & bus.DR;
            OP_LDA: single_res = bus.DR;
            OP_CMA: single_res = ~bus.AC;
            OP_CIR: begin
                single_res = {e_reg, bus.AC[WIDTH-1:1]};
                single_co  = bus.AC[0];
                single_e   = bus.AC[0];
            end
            OP_CIL: begin
                single_res = {bus.AC[WIDTH-2:0], e_reg};
                single_co  = bus.AC[WIDTH-1];
                single_e   = bus.AC[WIDTH-1];
            end
            OP_SUB: begin
                {single_co, single_res} = sub_sum;
                single_ovf = (bus.AC[WIDTH-1] != bus.DR[WIDTH-1]) &&
                             (sub_sum[WIDTH-1] != bus.AC[WIDTH-1]);
                single_e   = sub_sum[WIDTH];
            end
            // Only reached here for a zero divisor; nonzero divisors iterate.
            OP_DIV: begin
                single_res = '1;
                single_hi  = bus.AC;
                single_dz  = 1'b1;
            end
            OP_CLE: single_e = 1'b0;
            OP_CME: single_e = ~e_reg;
            default: ;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        work_hi_next = work_hi_reg;
        work_lo_next = work_lo_reg;
        operand_next = operand_reg;
        result_next  = result_reg;
        hi_next      = hi_reg;
        e_next       = e_reg;
        co_next      = co_reg;
        ovf_next     = ovf_reg;
        n_next       = n_reg;
        z_next       = z_reg;
        dz_next      = dz_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.OPSEL == OP_MUL || (bus.OPSEL == OP_DIV && bus.DR != '0)) begin
                        state_next   = (bus.OPSEL == OP_MUL) ? MUL : DIV;
                        work_hi_next = '0;
                        work_lo_next = bus.AC;
                        operand_next = bus.DR;
                        count_next   = '0;
                    end else begin
                        result_next = single_res;
                        hi_next     = single_hi;
                        e_next      = single_e;
                        co_next     = single_co;
                        ovf_next    = single_ovf;
                        n_next      = single_res[WIDTH-1];
                        z_next      = (single_res == '0);
                        dz_next     = single_dz;
                        done_next   = 1'b1;
                    end
                end
            end
            MUL, DIV: begin
                if (state_reg == MUL) begin
                    work_hi_next = mul_sum[WIDTH:1];
                    work_lo_next = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
                end else begin
                    work_hi_next = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    work_lo_next = {work_lo_reg[WIDTH-2:0], div_ok};
                end
                count_next = count_reg + CW'(1);
                if (count_reg == CW'(WIDTH - 1)) begin
                    state_next  = IDLE;
                    count_next  = '0;
                    result_next = work_lo_next;
                    hi_next     = work_hi_next;
                    co_next     = 1'b0;
                    ovf_next    = 1'b0;
                    dz_next     = 1'b0;
                    done_next   = 1'b1;
                    if (state_reg == MUL) begin
                        n_next = work_hi_next[WIDTH-1];
                        z_next = ({work_hi_next, work_lo_next} == '0);
                    end else begin
                        n_next = work_lo_next[WIDTH-1];
                        z_next = (work_lo_next == '0);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= '0;
            operand_reg <= '0;
            result_reg  <= '0;
            hi_reg      <= '0;
            e_reg       <= 1'b0;
            co_reg      <= 1'b0;
            ovf_reg     <= 1'b0;
            n_reg       <= 1'b0;
            z_reg       <= 1'b0;
            dz_reg      <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            work_hi_reg <= work_hi_next;
            work_lo_reg <= work_lo_next;
            operand_reg <= operand_next;
            result_reg  <= result_next;
            hi_reg      <= hi_next;
            e_reg       <= e_next;
            co_reg      <= co_next;
            ovf_reg     <= ovf_next;
            n_reg       <= n_next;
            z_reg       <= z_next;
            dz_reg      <= dz_next;
            done_reg    <= done_next;
        end
    end

    assign bus.busy   = (state_reg != IDLE);
    assign bus.done   = done_reg;
    assign bus.RESULT = result_reg;
    assign bus.HI     = hi_reg;
    assign bus.E      = e_reg;
    assign bus.CO     = co_reg;
    assign bus.OVF    = ovf_reg;
    assign bus.N      = n_reg;
    assign bus.Z      = z_reg;
    assign bus.DZ     = dz_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: driver queues hand-computed results, a monitor
// pops and compares them on every done pulse; the driver checks timing.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        logic [15:0] result;
        logic [15:0] hi;
        logic        e, co, ovf, n, z, dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   assertions = 0;
    int   failures   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        assertions++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                assertions++;
                failures++;
                $display("FAIL unexpected_done: got done=1, expected no pending op");
            end else begin
                mon_exp = sb.pop_front();
                chk({mon_exp.name, ".RESULT"}, bus.RESULT, mon_exp.result);
                chk({mon_exp.name, ".HI"},     bus.HI,     mon_exp.hi);
                chk({mon_exp.name, ".E"},      bus.E,      mon_exp.e);
                chk({mon_exp.name, ".CO"},     bus.CO,     mon_exp.co);
                chk({mon_exp.name, ".OVF"},    bus.OVF,    mon_exp.ovf);
                chk({mon_exp.name, ".N"},      bus.N,      mon_exp.n);
                chk({mon_exp.name, ".Z"},      bus.Z,      mon_exp.z);
                chk({mon_exp.name, ".DZ"},     bus.DZ,     mon_exp.dz);
                $display("op %-8s RESULT=%04h HI=%04h E=%b CO=%b OVF=%b N=%b Z=%b DZ=%b",
                         mon_exp.name, bus.RESULT, bus.HI, bus.E, bus.CO, bus.OVF,
                         bus.N, bus.Z, bus.DZ);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".busy"},   bus.busy,   0);
        chk({tag, ".done"},   bus.done,   0);
        chk({tag, ".RESULT"}, bus.RESULT, 0);
        chk({tag, ".HI"},     bus.HI,     0);
        chk({tag, ".flags"},  {bus.E, bus.CO, bus.OVF, bus.N, bus.Z, bus.DZ}, 0);
    endtask

    // Issue one operation (start is driven during the current cycle, which may
    // be the previous op's done cycle) and check done latency and busy length.
    task automatic do_op(input string name, input logic [3:0] op,
                         input logic [15:0] ac, input logic [15:0] dr,
                         input logic [15:0] er, input logic [15:0] eh,
                         input logic ee, input logic eco, input logic eovf,
                         input logic en, input logic ez, input logic edz,
                         input int lat, input bit disturb);
        exp_t x;
        int   n;
        int   busy_cnt;
        x.name = name; x.result = er; x.hi = eh; x.e = ee; x.co = eco;
        x.ovf = eovf; x.n = en; x.z = ez; x.dz = edz;
        sb.push_back(x);
        bus.start = 1'b1;
        bus.OPSEL = op;
        bus.AC    = ac;
        bus.DR    = dr;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (disturb) begin
                bus.AC = 16'($urandom);
                bus.DR = 16'($urandom);
                if (n == 4) begin
                    bus.start = 1'b1;
                    bus.OPSEL = 4'b0000;
                end
                if (n == 6) bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, ".latency"},     32'(n),        32'(lat));
        chk({name, ".busy_cycles"}, 32'(busy_cnt), 32'(lat));
        chk({name, ".busy_at_done"}, bus.busy,     0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.OPSEL = 4'b0;
        bus.AC    = '0;
        bus.DR    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        //     name      op       AC       DR       RESULT   HI      E  CO OV N  Z  DZ lat dist
        do_op("add_ovf", 4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 0, 0, 1, 1, 0, 0, 0, 0);
        do_op("sub_brw", 4'b0110, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0);
        do_op("sub_ok",  4'b0110, 16'h0005, 16'h0003, 16'h0002, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 0);
        do_op("mul_max", 4'b0111, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1, 0, 0, 1, 0, 0, 16, 1);
        do_op("div_7",   4'b1000, 16'd100,  16'd7,    16'd14,   16'd2,    1, 0, 0, 0, 0, 0, 16, 0);
        do_op("div_0",   4'b1000, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0, 0, 1, 0, 1, 0, 0);
        do_op("cle",     4'b1001, 16'h0000, 16'h5555, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0);
        do_op("cme",     4'b1010, 16'h1111, 16'h0000, 16'h1111, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0);
        do_op("cil",     4'b0101, 16'h8001, 16'h0000, 16'h0003, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 0);
        do_op("cir",     4'b0100, 16'h0002, 16'h0000, 16'h8001, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0);
        do_op("and",     4'b0001, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
        do_op("lda",     4'b0010, 16'h1234, 16'h8000, 16'h8000, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0);
        do_op("cma",     4'b0011, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0);
        do_op("nop",     4'b1111, 16'hABCD, 16'h1111, 16'hABCD, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0);
        do_op("mul_hi",  4'b0111, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 0, 0, 0, 0, 0, 0, 16, 0);
        do_op("mul_0",   4'b0111, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 16, 0);

        // Abort a MUL with reset: outputs clear on that edge, no done ever follows.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.OPSEL = 4'b0111;
        bus.AC    = 16'hFFFF;
        bus.DR    = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("abort.busy_started", bus.busy, 1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("abort");
        repeat (20) @(posedge clk);
        #1;
        do_op("add_post", 4'b0000, 16'h0001, 16'h0001, 16'h0002, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised accumulator ALU for the basic-computer datapath. It executes the existing single-cycle AC/DR operations plus multi-cycle unsigned multiply and divide. It owns the E (extend) flip-flop and registered status flags, and talks to the control unit through a start/busy/done handshake. It sits between the AC/DR registers and the AC load path, replacing the combinational ALU and the external E control logic.

## Interface
- WIDTH, 16, operand/result width; must be ≥ 4.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  operation request; sampled only in IDLE
- OPSEL  in  4  operation code, captured with start
- AC  in  WIDTH  accumulator operand, captured with start
- DR  in  WIDTH  data-register operand, captured with start
- busy  out  1  high while a MUL/DIV is iterating
- done  out  1  one-cycle pulse: RESULT/HI/flags/E valid and updated
- RESULT  out  WIDTH  result (low product word, quotient)
- HI  out  WIDTH  high product word / remainder; 0 for other ops
- E  out  1  extend flip-flop
- CO, OVF, N, Z, DZ  out  1 each  carry, signed overflow, negative, zero, divide-by-zero

## Operation
- States: IDLE, MUL, DIV. Operands and OPSEL are latched when start=1 in IDLE; later input changes are ignored until the next accepted start.
- start while busy=1 is ignored, not queued.
- OPSEL encoding and effects. All outputs update on completion; HI=0 unless stated.
  - 0000 ADD: {CO,RESULT}=AC+DR. OVF is signed overflow. E←CO.
  - 0001 AND: RESULT=AC&DR.
  - 0010 LDA: RESULT=DR.
  - 0011 CMA: RESULT=~AC.
  - 0100 CIR: RESULT={E,AC[WIDTH-1:1]}; CO=AC[0]; E←AC[0].
  - 0101 CIL: RESULT={AC[WIDTH-2:0],E}; CO=AC[WIDTH-1]; E←AC[WIDTH-1].
  - 0110 SUB: {CO,RESULT}=AC+~DR+1. CO=1 means no borrow. OVF is signed overflow. E←CO.
  - 0111 MUL: unsigned shift-add, one bit per cycle; {HI,RESULT}=AC*DR.
  - 1000 DIV: unsigned restoring, one bit per cycle; RESULT=AC/DR, HI=AC%DR.
  - 1001 CLE: E←0; RESULT=AC.
  - 1010 CME: E←~E; RESULT=AC.
  - others: NOP; RESULT=AC, E unchanged.
- CO and OVF are 0 for every op not listed as setting them.
- E is unchanged by any op not listed as writing it.
- DIV with DR=0: no iteration. Completes as a single-cycle op with RESULT=all ones, HI=AC, DZ=1. DZ=0 on every other completion.
- Z=(RESULT==0), except MUL, where Z=({HI,RESULT}==0).
- N=RESULT[WIDTH-1], except MUL, where N=HI[WIDTH-1].

## Timing
- Reset: state IDLE. busy, done, RESULT, HI, E, CO, OVF, N, Z, DZ all 0. Iteration counter cleared.
- rst during MUL/DIV aborts the operation: no done pulse; all outputs return to reset values on that edge.
- Single-cycle ops (including DIV by zero), start accepted at edge k:
  - outputs update at edge k;
  - done=1 for the cycle after edge k;
  - busy stays 0.
- MUL/DIV, start accepted at edge k:
  - busy=1 from edge k;
  - WIDTH iteration edges follow;
  - at edge k+WIDTH, outputs update, busy→0, done=1 for one cycle, state→IDLE.
- Outputs are held stable between done pulses. Intermediate partial products and remainders are never visible on RESULT or HI.
- The done cycle is an IDLE cycle, so start asserted during it is accepted. Back-to-back operations therefore have no bubble.
- Counter is ⌈log2(WIDTH+1)⌉ bits and wraps to 0 only on completion.

## Test plan
- Reset, then ADD AC=0x7FFF, DR=0x0001 -> next cycle: RESULT=0x8000, OVF=1, N=1, CO=0, E=0, Z=0, done high exactly 1 cycle.
- SUB AC=0x0003, DR=0x0005 -> RESULT=0xFFFE, CO=0, E=0, N=1. Then SUB AC=0x0005, DR=0x0003 started in the done cycle -> RESULT=0x0002, CO=1, E=1.
- MUL AC=0xFFFF, DR=0xFFFF -> busy high 16 cycles, done 16 edges after start: HI=0xFFFE, RESULT=0x0001, N=1, Z=0. Toggling AC/DR and start mid-operation has no effect.
- DIV AC=100, DR=7 -> after 16 cycles RESULT=14, HI=2, DZ=0. Then DIV AC=0x1234, DR=0 -> 1 cycle: RESULT=0xFFFF, HI=0x1234, DZ=1, busy never high.
- CME from E=0, then CIL AC=0x8001 -> RESULT=0x0003, CO=1, E=1. Then CIR AC=0x0002 -> RESULT=0x8001, CO=0, E=0.
- Start MUL, assert rst at cycle 5 -> busy=0 and all outputs 0 next edge, no done pulse. A subsequent ADD 1+1 -> RESULT=2 with normal 1-cycle timing.
